awg_cmd_decoder: RTL and testbench

//  Multi-channel AWG command decoder; successor to the single-byte control decoder.

---
 rtl/awg_cmd_decoder.sv | 196 +++++++++++++++++++
 tb/tb_awg_cmd_decoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_cmd_decoder.sv
// awg_cmd_decoder: framed UART command decoder driving per-channel AWG registers.
// Define AWG_SHADOW_LOAD_EN for shadow registers with a masked commit (reg_id 4).
module awg_cmd_decoder #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FREQ_W      = 16,
    parameter int unsigned AMP_W       = 10,
    parameter int unsigned OFF_W       = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 uart_data,
    input  logic                       data_valid,
    output logic [2*NUM_CH-1:0]        waveform_type,
    output logic [FREQ_W*NUM_CH-1:0]   frequency,
    output logic [AMP_W*NUM_CH-1:0]    amplitude,
    output logic [OFF_W*NUM_CH-1:0]    dc_offset,
    output logic [NUM_CH-1:0]          cfg_update,
    output logic                       pkt_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [FREQ_W-1:0] FREQ_RST = FREQ_W'(1);
    localparam logic [OFF_W-1:0] OFF_RST = {1'b1, {(OFF_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_D0,
        S_D1,
        S_CHK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       hdr;
    logic [7:0]       d0;
    logic [7:0]       d1;

    logic [1:0]        wave_q [NUM_CH];
    logic [FREQ_W-1:0] freq_q [NUM_CH];
    logic [AMP_W-1:0]  amp_q  [NUM_CH];
    logic [OFF_W-1:0]  off_q  [NUM_CH];

`ifdef AWG_SHADOW_LOAD_EN
    logic [1:0]        wave_s [NUM_CH];
    logic [FREQ_W-1:0] freq_s [NUM_CH];
    logic [AMP_W-1:0]  amp_s  [NUM_CH];
    logic [OFF_W-1:0]  off_s  [NUM_CH];
`endif

    logic [15:0]       data;
    logic [3:0]        ch;
    logic [3:0]        reg_id;
    logic              chk_ok;
    logic              ch_ok;
    logic              reg_ok;
    logic              accept;
    logic [1:0]        wave_val;
    logic [FREQ_W-1:0] freq_val;
    logic [AMP_W-1:0]  amp_val;
    logic [OFF_W-1:0]  off_val;

    // Decode of the buffered packet against the CHK byte currently on the bus.
    always_comb begin
        data     = {d1, d0};
        ch       = hdr[7:4];
        reg_id   = hdr[3:0];
        chk_ok   = (uart_data == (hdr ^ d0 ^ d1));
        ch_ok    = (32'(ch) < NUM_CH);
`ifdef AWG_SHADOW_LOAD_EN
        reg_ok   = (reg_id <= 4'd4);
`else
        reg_ok   = (reg_id <= 4'd3);
`endif
        accept   = chk_ok && ch_ok && reg_ok;
        wave_val = data[1:0];
        freq_val = data[FREQ_W-1:0];
        if (freq_val == '0) begin
            freq_val = FREQ_RST;
        end
        amp_val  = (|(data >> AMP_W)) ? '1 : data[AMP_W-1:0];
        off_val  = (|(data >> OFF_W)) ? '1 : data[OFF_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            hdr        <= '0;
            d0         <= '0;
            d1         <= '0;
            cfg_update <= '0;
            pkt_err    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                wave_q[k] <= '0;
                freq_q[k] <= FREQ_RST;
                amp_q[k]  <= '1;
                off_q[k]  <= OFF_RST;
`ifdef AWG_SHADOW_LOAD_EN
                wave_s[k] <= '0;
                freq_s[k] <= FREQ_RST;
                amp_s[k]  <= '1;
                off_s[k]  <= OFF_RST;
`endif
            end
        end else begin
            cfg_update <= '0;
            pkt_err    <= 1'b0;
            if (state == S_IDLE) begin
                tmo_cnt <= '0;
                if (data_valid && uart_data == SYNC_BYTE) begin
                    state <= S_HDR;
                end
            end else if (data_valid) begin
                tmo_cnt <= '0;
                unique case (state)
                    S_HDR: begin
                        hdr   <= uart_data;
                        state <= S_D0;
                    end
                    S_D0: begin
                        d0    <= uart_data;
                        state <= S_D1;
                    end
                    S_D1: begin
                        d1    <= uart_data;
                        state <= S_CHK;
                    end
                    S_CHK: begin
                        state <= S_IDLE;
                        if (!accept) begin
                            pkt_err <= 1'b1;
`ifdef AWG_SHADOW_LOAD_EN
                        end else if (reg_id == 4'd4) begin
                            cfg_update <= data[NUM_CH-1:0];
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (data[k]) begin
                                    wave_q[k] <= wave_s[k];
                                    freq_q[k] <= freq_s[k];
                                    amp_q[k]  <= amp_s[k];
                                    off_q[k]  <= off_s[k];
                                end
                            end
                        end else begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (ch == 4'(k)) begin
                                    case (reg_id)
                                        4'd0: wave_s[k] <= wave_val;
                                        4'd1: freq_s[k] <= freq_val;
                                        4'd2: amp_s[k]  <= amp_val;
                                        4'd3: off_s[k]  <= off_val;
                                        default: ;
                                    endcase
                                end
                            end
`else
                        end else begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (ch == 4'(k)) begin
                                    cfg_update[k] <= 1'b1;
                                    case (reg_id)
                                        4'd0: wave_q[k] <= wave_val;
                                        4'd1: freq_q[k] <= freq_val;
                                        4'd2: amp_q[k]  <= amp_val;
                                        4'd3: off_q[k]  <= off_val;
                                        default: ;
                                    endcase
                                end
                            end
`endif
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (tmo_cnt == CNT_LAST) begin
                // A byte arriving on the expiry cycle takes the branch above instead.
                state   <= S_IDLE;
                tmo_cnt <= '0;
                pkt_err <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign waveform_type[2*k +: 2]  = wave_q[k];
        assign frequency[FREQ_W*k +: FREQ_W] = freq_q[k];
        assign amplitude[AMP_W*k +: AMP_W]   = amp_q[k];
        assign dc_offset[OFF_W*k +: OFF_W]   = off_q[k];
    end

endmodule

// File: tb/tb_awg_cmd_decoder.sv
// tb_awg_cmd_decoder: randomized packet stimulus with a packet-level model and
// a scoreboard that checks every cfg_update/pkt_err pulse and register snapshot.
`timescale 1ns/1ps
module tb_awg_cmd_decoder;

    localparam int NUM_CH = 2;
    localparam int FREQ_W = 16;
    localparam int AMP_W  = 10;
    localparam int OFF_W  = 10;
    localparam int TMO    = 20;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef AWG_SHADOW_LOAD_EN
    localparam int MAX_RID = 4;
`else
    localparam int MAX_RID = 3;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [7:0]                uart_data = '0;
    logic                      data_valid = 1'b0;
    logic [2*NUM_CH-1:0]       waveform_type;
    logic [FREQ_W*NUM_CH-1:0]  frequency;
    logic [AMP_W*NUM_CH-1:0]   amplitude;
    logic [OFF_W*NUM_CH-1:0]   dc_offset;
    logic [NUM_CH-1:0]         cfg_update;
    logic                      pkt_err;

    awg_cmd_decoder #(
        .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .AMP_W(AMP_W), .OFF_W(OFF_W),
        .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .uart_data(uart_data), .data_valid(data_valid),
        .waveform_type(waveform_type), .frequency(frequency),
        .amplitude(amplitude), .dc_offset(dc_offset),
        .cfg_update(cfg_update), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0]        cfg;
        logic                     err;
        logic [2*NUM_CH-1:0]      wave;
        logic [FREQ_W*NUM_CH-1:0] freq;
        logic [AMP_W*NUM_CH-1:0]  amp;
        logic [OFF_W*NUM_CH-1:0]  off;
    } exp_t;

    exp_t exp_q[$];
    int m_wave[NUM_CH], m_freq[NUM_CH], m_amp[NUM_CH], m_off[NUM_CH];
    int s_wave[NUM_CH], s_freq[NUM_CH], s_amp[NUM_CH], s_off[NUM_CH];
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_wave[k] = 0;
            m_freq[k] = 1;
            m_amp[k]  = (1 << AMP_W) - 1;
            m_off[k]  = 1 << (OFF_W - 1);
            s_wave[k] = m_wave[k];
            s_freq[k] = m_freq[k];
            s_amp[k]  = m_amp[k];
            s_off[k]  = m_off[k];
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.cfg = '0;
        e.err = 1'b0;
        e.wave = '0;
        e.freq = '0;
        e.amp = '0;
        e.off = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            e.wave[2*k +: 2]           = 2'(m_wave[k]);
            e.freq[FREQ_W*k +: FREQ_W] = FREQ_W'(m_freq[k]);
            e.amp[AMP_W*k +: AMP_W]    = AMP_W'(m_amp[k]);
            e.off[OFF_W*k +: OFF_W]    = OFF_W'(m_off[k]);
        end
        return e;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic int fword(input int v);
        int f = v % (1 << FREQ_W);
        return (f == 0) ? 1 : f;
    endfunction

    // Packet-level outcome: one expected event per accepted or rejected packet.
    function automatic void model_packet(input logic [7:0] h, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
        int ch = int'(h[7:4]);
        int rid = int'(h[3:0]);
        int data = int'({b, a});
        exp_t e;
        if (c != (h ^ a ^ b) || ch >= NUM_CH || rid > MAX_RID) begin
            e = snap();
            e.err = 1'b1;
            exp_q.push_back(e);
            return;
        end
`ifdef AWG_SHADOW_LOAD_EN
        if (rid == 4) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (((data >> k) & 1) == 1) begin
                    m_wave[k] = s_wave[k];
                    m_freq[k] = s_freq[k];
                    m_amp[k]  = s_amp[k];
                    m_off[k]  = s_off[k];
                end
            end
            e = snap();
            e.cfg = NUM_CH'(data);
            exp_q.push_back(e);
        end else begin
            case (rid)
                0: s_wave[ch] = data % 4;
                1: s_freq[ch] = fword(data);
                2: s_amp[ch]  = sat(data, AMP_W);
                default: s_off[ch] = sat(data, OFF_W);
            endcase
        end
`else
        case (rid)
            0: m_wave[ch] = data % 4;
            1: m_freq[ch] = fword(data);
            2: m_amp[ch]  = sat(data, AMP_W);
            default: m_off[ch] = sat(data, OFF_W);
        endcase
        e = snap();
        e.cfg = NUM_CH'(1 << ch);
        exp_q.push_back(e);
`endif
    endfunction

    task automatic tick(input logic v, input logic [7:0] b);
        uart_data = b;
        data_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic int rgap();
        int r = $urandom_range(0, 19);
        if (r == 0) return TMO - 1;
        if (r < 12) return 0;
        return $urandom_range(1, 3);
    endfunction

    task automatic send_packet(input logic [7:0] h, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] c);
        logic [7:0] pk[5];
        pk[0] = SYNC;
        pk[1] = h;
        pk[2] = a;
        pk[3] = b;
        pk[4] = c;
        model_packet(h, a, b, c);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, pk[i]);
            if (i < 4) repeat (rgap()) tick(1'b0, 8'($urandom));
        end
    endtask

    task automatic send_trunc(input int n);
        exp_t e = snap();
        e.err = 1'b1;
        exp_q.push_back(e);
        tick(1'b1, SYNC);
        for (int i = 0; i < n; i++) tick(1'b1, 8'($urandom));
        repeat (TMO) tick(1'b0, 8'($urandom));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1'b0, 8'h00);
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected events never seen, required 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_state(input string tag);
        exp_t e = snap();
        check({tag, "_wave"}, 64'(waveform_type), 64'(e.wave));
        check({tag, "_freq"}, 64'(frequency), 64'(e.freq));
        check({tag, "_amp"}, 64'(amplitude), 64'(e.amp));
        check({tag, "_off"}, 64'(dc_offset), 64'(e.off));
        check({tag, "_cfg"}, 64'(cfg_update), 64'(0));
        check({tag, "_err"}, 64'(pkt_err), 64'(0));
    endtask

    // Monitor: every output pulse consumes exactly one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (cfg_update != '0 || pkt_err)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: cfg_update=%b pkt_err=%b, required none",
                             cfg_update, pkt_err);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_cfg_update", 64'(cfg_update), 64'(e.cfg));
                    check("sb_pkt_err", 64'(pkt_err), 64'(e.err));
                    check("sb_wave", 64'(waveform_type), 64'(e.wave));
                    check("sb_freq", 64'(frequency), 64'(e.freq));
                    check("sb_amp", 64'(amplitude), 64'(e.amp));
                    check("sb_off", 64'(dc_offset), 64'(e.off));
                end
            end
        end
    end

    initial begin
        logic [7:0] h, a, b, c, nz;
        int sel;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b0, 8'h00);
        check_state("reset");

        send_packet(8'h11, 8'h34, 8'h12, 8'h37);
        repeat (3) tick(1'b0, 8'h00);
`ifndef AWG_SHADOW_LOAD_EN
        check("t1_ch1_freq", 64'(frequency[2*FREQ_W-1:FREQ_W]), 64'h1234);
`endif
        send_packet(8'h11, 8'h34, 8'h12, 8'h00);
        send_packet(8'h01, 8'hFF, 8'h00, 8'hFE);
        send_packet(8'h02, 8'h00, 8'h08, 8'h0A);
        send_packet(8'h01, 8'h00, 8'h00, 8'h01);
        repeat (3) tick(1'b0, 8'h00);
`ifndef AWG_SHADOW_LOAD_EN
        check("t3_ch0_amp_sat", 64'(amplitude[AMP_W-1:0]), 64'h3FF);
        check("t3_ch0_freq_zero", 64'(frequency[FREQ_W-1:0]), 64'h1);
`endif
        tick(1'b1, 8'h3C);
        send_trunc(1);
        send_packet(8'h11, 8'h34, 8'h12, 8'h37);
        send_packet(8'h31, 8'h05, 8'h00, 8'h34);
        send_packet(8'h04, 8'h02, 8'h00, 8'h06);
        repeat (3) tick(1'b0, 8'h00);
        check("t6_ch1_freq", 64'(frequency[2*FREQ_W-1:FREQ_W]), 64'h1234);
        drain();

        tick(1'b1, SYNC);
        tick(1'b1, 8'h11);
        rst = 1'b1;
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        model_reset();
        rst = 1'b0;
        tick(1'b0, 8'h00);
        check_state("midrst");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do nz = 8'($urandom); while (nz == SYNC);
                tick(1'b1, nz);
            end
            if ($urandom_range(0, 19) == 0) begin
                send_trunc($urandom_range(0, 3));
            end else begin
                h = {4'($urandom_range(0, NUM_CH)), 4'($urandom_range(0, 5))};
                sel = $urandom_range(0, 3);
                case (sel)
                    0: {b, a} = 16'h0000;
                    1: {b, a} = 16'($urandom_range(0, 1023));
                    2: {b, a} = 16'hFFFF;
                    default: {b, a} = 16'($urandom);
                endcase
                c = h ^ a ^ b;
                if ($urandom_range(0, 19) < 3) c = c ^ 8'($urandom_range(1, 255));
                send_packet(h, a, b, c);
            end
            if ($urandom_range(0, 1) == 0) tick(1'b0, 8'($urandom));
        end

        drain();
        repeat (2) tick(1'b0, 8'h00);
        check_state("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
